pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Producer of the `StopWidth stall vector consumed by every pipeline register (pc, if_id, de_ex, ex_mem, mem_wb).
//   Arbitrates ID/EX stall requests and flush, and sequences multi-cycle EX ops (madd/msub/div) through a counter FSM.
//   Drives stop so a register holds when its own bit is `Stop, and inserts a NOP bubble when stop[k]=`Stop and stop[k+1]=`NoStop.
//   Also keeps a saturating stall-cycle performance counter.
// PARAMETERS
//   STOP_W  6   width of stop vector (bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB)
//   CNT_W   6   width of multi-cycle length / down-counter (max op length 63)
//   PERF_W  32  width of stall-cycle counter
// PORTS
//   clk           in   1       clock, all state on rising edge
//   rst           in   1       asynchronous reset, active-high
//   stallreq_id   in   1       ID stall request (load-use), level
//   stallreq_ex   in   1       EX stall request, level
//   mc_start      in   1       EX begins multi-cycle op this cycle (1-cycle pulse)
//   mc_len        in   CNT_W   total EX-occupancy cycles of that op; sampled when mc_start=1
//   flush_req     in   1       pipeline flush (exception/eret), level
//   perf_clr      in   1       synchronous clear of stall_cycles
//   stop          out  STOP_W  stall vector to pipeline registers, `Stop=1 / `NoStop=0
//   flush_o       out  1       flush to all pipeline registers
//   mc_busy       out  1       FSM in MC_BUSY
//   mc_done       out  1       1-cycle pulse: multi-cycle result valid in EX this cycle
//   stall_cycles  out  PERF_W  count of cycles with stop[0]=`Stop
// BEHAVIOUR
//   Reset (async, rst=1): state=RUN, cnt=0, stall_cycles=0; stop=0, flush_o=0, mc_busy=0, mc_done=0.
//   FSM states RUN, MC_BUSY, MC_DONE; registered. stop/flush_o/mc_done are combinational from state and inputs (same-cycle).
//   stop priority (highest first):
//     flush_req=1 -> stop=6'b000000, flush_o=1.
//     EX stall (state==MC_BUSY, or RUN & mc_start & mc_len>=2, or stallreq_ex) -> stop=6'b001111.
//     stallreq_id -> stop=6'b000111 (ID/EX receives bubble).
//     else -> stop=6'b000000.
//   Transitions (when flush_req=0):
//     RUN: mc_start & mc_len>=3 -> MC_BUSY, cnt<=mc_len-2.
//          mc_start & mc_len==2 -> MC_DONE.
//          mc_start & mc_len<2 -> ignored, stay RUN, no stall, no mc_done.
//     MC_BUSY: cnt<=cnt-1; when cnt==1 -> MC_DONE.
//     MC_DONE: mc_done=1, EX stall released, -> RUN. mc_start in this cycle is honoured as if in RUN.
//     mc_start outside RUN/MC_DONE is ignored.
//   Op of length N: EX stalled for exactly N-1 cycles starting in the mc_start cycle; mc_done in cycle N-1 after mc_start.
//   flush_req=1 in any state: next state RUN, cnt<=0, no mc_done pulse (op aborted). flush overrides mc_start.
//   stall_cycles: +1 each cycle stop[0]=1; saturates at all-ones; perf_clr has priority over increment (result 0).
//   Mid-op reset: FSM returns to RUN immediately, stop drops to 0 asynchronously.
// STRUCTURE
//   define.v gets: `Stop/`NoStop, `StopWidth, STOP_PAT_ID=6'b000111, STOP_PAT_EX=6'b001111, FSM state codes.
//   Sub-module sat_counter (PERF_W, inc, clr) for stall_cycles; FSM, counter and stop mux inline.
// TESTING
//   Reset release, no requests -> stop=0, flush_o=0, stall_cycles=0 for 10 cycles.
//   stallreq_id for 1 cycle -> stop=6'b000111 that cycle only; stall_cycles=1.
//   mc_start with mc_len=4 -> stop=6'b001111 for 3 cycles (t..t+2); mc_busy=1 at t+1,t+2; mc_done=1 at t+3 with stop=0.
//   mc_len=2 -> 1 stall cycle, mc_done at t+1. mc_len=1 -> no stall, no mc_done.
//   flush_req at t+1 of a mc_len=10 op -> stop=0, flush_o=1 at t+1; RUN at t+2; mc_done never pulses.
//   stallreq_id together with MC_BUSY -> stop=6'b001111. Preloaded stall_cycles=all-ones -> stays all-ones while stalling; perf_clr -> 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller:
// stop-vector encodings, stall patterns and the multi-cycle FSM states.
package pipeline_stall_ctrl_pkg;

  localparam int DEF_STOP_W = 6;
  localparam int DEF_CNT_W  = 6;
  localparam int DEF_PERF_W = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam logic [DEF_STOP_W-1:0] STOP_PAT_NONE = 6'b000000;
  localparam logic [DEF_STOP_W-1:0] STOP_PAT_ID   = 6'b000111;
  localparam logic [DEF_STOP_W-1:0] STOP_PAT_EX   = 6'b001111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, clear to zero on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: arbitrates flush / EX / ID stall requests into
// the stop vector, sequences multi-cycle EX ops and counts stalled cycles.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int STOP_W = DEF_STOP_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PERF_W = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_len,
  input  logic              flush_req,
  input  logic              perf_clr,
  output logic [STOP_W-1:0] stop,
  output logic              flush_o,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] stall_cycles
);

  mc_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             mc_accept;
  logic             ex_stall;

  // A new op may be accepted when idle or in the cycle its predecessor completes.
  always_comb begin
    mc_accept = mc_start && ((state == RUN) || (state == MC_DONE));
    ex_stall  = (state == MC_BUSY) || (mc_accept && (mc_len >= CNT_W'(2))) || stallreq_ex;
  end

  // Stop-vector priority mux: flush, then EX stall, then ID stall.
  always_comb begin
    stop = STOP_W'(STOP_PAT_NONE);
    if (flush_req) begin
      stop = STOP_W'(STOP_PAT_NONE);
    end else if (ex_stall) begin
      stop = STOP_W'(STOP_PAT_EX);
    end else if (stallreq_id) begin
      stop = STOP_W'(STOP_PAT_ID);
    end
  end

  assign flush_o = flush_req;
  assign mc_done = (state == MC_DONE) && !flush_req;

  // Multi-cycle FSM with its down-counter and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      mc_busy <= 1'b0;
    end else if (flush_req) begin
      state   <= RUN;
      cnt     <= '0;
      mc_busy <= 1'b0;
    end else begin
      case (state)
        MC_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= MC_DONE;
            mc_busy <= 1'b0;
          end
        end
        default: begin
          if (mc_accept && (mc_len >= CNT_W'(3))) begin
            state   <= MC_BUSY;
            cnt     <= mc_len - CNT_W'(2);
            mc_busy <= 1'b1;
          end else if (mc_accept && (mc_len == CNT_W'(2))) begin
            state   <= MC_DONE;
            mc_busy <= 1'b0;
          end else begin
            state   <= RUN;
            mc_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .W(PERF_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stop[0] == STOP),
    .clr  (perf_clr),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        mc_start = 1'b0;
  logic [5:0]  mc_len = '0;
  logic        flush_req = 1'b0;
  logic        perf_clr = 1'b0;
  logic [5:0]  stop;
  logic        flush_o, mc_busy, mc_done;
  logic [31:0] stall_cycles;
  logic [5:0]  stop_s;
  logic        flush_o_s, mc_busy_s, mc_done_s;
  logic [3:0]  stall_cycles_s;

  int nChecks = 0;
  int nFails  = 0;

  // Model: stall cycles still owed by the running op, a pending completion and perf counts
  int      busyLeft = 0;
  bit      donePending = 1'b0;
  longint  perfBig = 0;
  longint  perfSmall = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .perf_clr(perf_clr),
    .stop(stop), .flush_o(flush_o), .mc_busy(mc_busy), .mc_done(mc_done),
    .stall_cycles(stall_cycles)
  );

  // Narrow perf counter instance so saturation is reachable in a short run
  pipeline_stall_ctrl #(.PERF_W(4)) dut_small (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req), .perf_clr(perf_clr),
    .stop(stop_s), .flush_o(flush_o_s), .mc_busy(mc_busy_s), .mc_done(mc_done_s),
    .stall_cycles(stall_cycles_s)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model for the current cycle, then advance the model
  task automatic checkOutput();
    bit       opStall, accepting;
    logic [5:0] expStop;
    accepting = (busyLeft == 0);
    opStall   = (busyLeft > 0) || (accepting && mc_start && mc_len >= 2);
    if (flush_req)                      expStop = 6'h00;
    else if (opStall || stallreq_ex)    expStop = 6'h0F;
    else if (stallreq_id)               expStop = 6'h07;
    else                                expStop = 6'h00;
    checkVal("stop",         stop,           expStop);
    checkVal("flush_o",      flush_o,        flush_req);
    checkVal("mc_done",      mc_done,        donePending && !flush_req);
    checkVal("mc_busy",      mc_busy,        busyLeft > 0);
    checkVal("stall_cycles", stall_cycles,   perfBig);
    checkVal("stall_small",  stall_cycles_s, perfSmall);
    checkVal("stop_small",   stop_s,         expStop);
    if (perf_clr) begin
      perfBig = 0; perfSmall = 0;
    end else if (expStop[0]) begin
      if (perfBig < 64'hFFFF_FFFF) perfBig++;
      if (perfSmall < 15) perfSmall++;
    end
    if (flush_req) begin
      busyLeft = 0; donePending = 1'b0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      donePending = (busyLeft == 0);
    end else if (mc_start && mc_len >= 2) begin
      busyLeft = int'(mc_len) - 2;
      donePending = (mc_len == 2);
    end else begin
      donePending = 1'b0;
    end
  endtask

  // Drive one cycle of inputs just after the falling edge and check it
  task automatic applyStimulus(input bit id, input bit ex, input bit start,
                               input int len, input bit fl, input bit clr);
    @(negedge clk);
    stallreq_id = id; stallreq_ex = ex; mc_start = start;
    mc_len = 6'(len); flush_req = fl; perf_clr = clr;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    #2;
    checkVal("reset_stop", stop, 6'h00);
    checkVal("reset_busy", mc_busy, 1'b0);
    checkVal("reset_perf", stall_cycles, 32'h0);
    @(negedge clk); rst = 1'b0;

    idle(10);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(2);
    // len 4, len 2, len 1
    applyStimulus(0, 0, 1, 4, 0, 0); idle(5);
    applyStimulus(0, 0, 1, 2, 0, 0); idle(3);
    applyStimulus(0, 0, 1, 1, 0, 0); idle(3);
    applyStimulus(0, 0, 1, 0, 0, 0); idle(2);
    // Flush at t+1 of a length-10 op
    applyStimulus(0, 0, 1, 10, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0); idle(12);
    // ID request overlapping a busy op, plus ignored mc_start while busy
    applyStimulus(0, 0, 1, 5, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 9, 0, 0);
    idle(4);
    // Back-to-back op accepted in the completion cycle
    applyStimulus(0, 0, 1, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 3, 0, 0);
    idle(4);
    // Flush in the completion cycle suppresses mc_done; EX request alone
    applyStimulus(0, 0, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0);
    idle(2);
    // Saturate the narrow counter, then clear both
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    idle(2);
    // Mid-op asynchronous reset
    applyStimulus(0, 0, 1, 12, 0, 0);
    idle(2);
    #2 rst = 1'b1;
    #1;
    checkVal("midop_reset_stop", stop, 6'h00);
    checkVal("midop_reset_busy", mc_busy, 1'b0);
    checkVal("midop_reset_perf", stall_cycles, 32'h0);
    busyLeft = 0; donePending = 1'b0; perfBig = 0; perfSmall = 0;
    @(negedge clk); rst = 1'b0;
    idle(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int len;
      len = ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 8));
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, len,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 49) == 0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
